// File: rtl/decim_pkg.sv
// Shared types and helpers for the handshaked decimator.
package decim_pkg;

  localparam int DEC_DATA_W     = 16;
  localparam int DEC_MAX_FACTOR = 16;

  typedef logic signed [DEC_DATA_W-1:0] sample_t;

  typedef enum logic {
    DEC_PICK = 1'b0,
    DEC_AVG  = 1'b1
  } dec_mode_e;

  // 0 behaves as 1; anything above the supported maximum saturates to it.
  function automatic int unsigned clamp_factor(input int unsigned f, input int unsigned max_f);
    if (f == 0) return 1;
    else if (f > max_f) return max_f;
    else return f;
  endfunction

  function automatic int unsigned floor_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 1; i < 32; i++) begin
      if (v >= (32'd1 << i)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/decim_avg_acc.sv
// Boxcar accumulator: running sum of a frame, arithmetic right shift by
// floor(log2(factor)), then saturation back to the sample range.
module decim_avg_acc #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 20,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               valid,
  input  logic               first,
  input  logic [DATA_W-1:0]  sample,
  input  logic [SHIFT_W-1:0] shift,
  output logic [DATA_W-1:0]  result
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;

  assign ext     = {{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample};
  // The first sample of a frame replaces whatever the accumulator held.
  assign sum     = first ? ext : acc + ext;
  assign shifted = sum >>> shift;

  always_comb begin
    result = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) result = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc <= '0;
    else if (clear) acc <= '0;
    else if (valid) acc <= sum;
  end

endmodule

// File: rtl/decimator_param.sv
// Handshaked decimator: pick-last, or boxcar average when DECIMATOR_AVG_EN is
// defined. Counts accepted input samples; factor and mode are latched per frame.
module decimator_param
  import decim_pkg::*;
#(
  parameter int DATA_W     = DEC_DATA_W,
  parameter int MAX_FACTOR = DEC_MAX_FACTOR,
  parameter int CNT_W      = $clog2(MAX_FACTOR + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CNT_W-1:0]  factor_i,
  input  logic              mode_avg_i,
  input  logic [DATA_W-1:0] signal_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] signal_out,
  output logic              valid_out,
  input  logic              out_ready,
  output logic              overrun_o,
  input  logic              clear_i
);

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  factor_lat;
  logic [CNT_W-1:0]  eff_factor;
  logic [DATA_W-1:0] result;
  logic              first;
  logic              take;
  logic              frame_end;
  logic              load;

  assign first      = (count == '0);
  assign eff_factor = first ? CNT_W'(clamp_factor(32'(factor_i), MAX_FACTOR)) : factor_lat;
  assign take       = valid_in && !clear_i;
  assign count_nxt  = count + CNT_W'(1);
  assign frame_end  = take && (count_nxt == eff_factor);
  // Output handshake: a result transfers on any edge with valid_out && out_ready;
  // signal_out is stable while valid_out is high, and a new result may replace
  // the old one only on the edge where the old one transfers.
  assign load       = frame_end && (!valid_out || out_ready);

`ifdef DECIMATOR_AVG_EN
  localparam int ACC_W = DATA_W + $clog2(MAX_FACTOR);

  dec_mode_e         mode_lat;
  dec_mode_e         eff_mode;
  logic [DATA_W-1:0] avg_res;

  assign eff_mode = first ? (mode_avg_i ? DEC_AVG : DEC_PICK) : mode_lat;

  decim_avg_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT_W(CNT_W)
  ) u_avg_acc (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear_i),
    .valid  (take),
    .first  (first),
    .sample (signal_in),
    .shift  (CNT_W'(floor_log2(32'(eff_factor)))),
    .result (avg_res)
  );

  assign result = (eff_mode == DEC_AVG) ? avg_res : signal_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mode_lat <= DEC_PICK;
    else if (take && first) mode_lat <= eff_mode;
  end
`else
  logic unused_mode;
  assign unused_mode = mode_avg_i;
  assign result      = signal_in;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      factor_lat <= CNT_W'(1);
      signal_out <= '0;
      valid_out  <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      if (clear_i) begin
        count     <= '0;
        overrun_o <= 1'b0;
      end else if (valid_in) begin
        if (first) factor_lat <= eff_factor;
        count <= frame_end ? '0 : count_nxt;
        if (frame_end && valid_out && !out_ready) overrun_o <= 1'b1;
      end
      if (load) begin
        valid_out  <= 1'b1;
        signal_out <= result;
      end else if (valid_out && out_ready) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decimator_param.sv
// Directed bench for decimator_param; averaging checks are built when
// DECIMATOR_AVG_EN is defined, otherwise mode_avg_i is checked to be ignored.
module tb_decimator_param;

  localparam int DATA_W     = 16;
  localparam int MAX_FACTOR = 16;
  localparam int CNT_W      = $clog2(MAX_FACTOR + 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [CNT_W-1:0]  factor_i = '0;
  logic              mode_avg_i = 1'b0;
  logic [DATA_W-1:0] signal_in = '0;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] signal_out;
  logic              valid_out;
  logic              out_ready = 1'b1;
  logic              overrun_o;
  logic              clear_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] exp_q[$];

  decimator_param #(.DATA_W(DATA_W), .MAX_FACTOR(MAX_FACTOR)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .factor_i  (factor_i),
    .mode_avg_i(mode_avg_i),
    .signal_in (signal_in),
    .valid_in  (valid_in),
    .signal_out(signal_out),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .overrun_o (overrun_o),
    .clear_i   (clear_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] s);
    signal_in = s;
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if (signal_out !== '0) begin
      miscompares++; $display("FAIL reset_signal_out: got %0d expected 0", signal_out);
    end
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid_out: got %b expected 0", valid_out);
    end
    vectors++;
    if (overrun_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun_o);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_pick_ramp();
    logic [DATA_W-1:0] e;
    factor_i = 5'd4; mode_avg_i = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      signal_in = DATA_W'(i);
      valid_in  = 1'b1;
      tick();
      if (i % 4 == 3) exp_q.push_back(DATA_W'(i));
      vectors++;
      if (valid_out !== (i % 4 == 3)) begin
        miscompares++; $display("FAIL ramp_valid[%0d]: got %b expected %b", i, valid_out, (i % 4 == 3));
      end
      if (valid_out === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (signal_out !== e) begin
          miscompares++; $display("FAIL ramp_data[%0d]: got %0d expected %0d", i, signal_out, e);
        end
      end
    end
    valid_in = 1'b0;
    tick();
    vectors++;
    if (valid_out !== 1'b0 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL ramp_drain: got valid %b pending %0d expected 0 0", valid_out, exp_q.size());
    end
  endtask

  task automatic test_factor_one();
    logic [DATA_W-1:0] vals[4];
    vals[0] = 16'hfffb; vals[1] = 16'd1234; vals[2] = 16'h8000; vals[3] = 16'h7fff;
    for (int f = 0; f < 2; f++) begin
      factor_i = CNT_W'(1 - f);
      for (int i = 0; i < 4; i++) begin
        signal_in = vals[i];
        valid_in  = 1'b1;
        tick();
        vectors++;
        if (valid_out !== 1'b1 || signal_out !== vals[i]) begin
          miscompares++;
          $display("FAIL echo_f%0d[%0d]: got %b/%0d expected 1/%0d", 1 - f, i, valid_out, signal_out, vals[i]);
        end
      end
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_clamp();
    factor_i = 5'd31;
    for (int i = 0; i < 32; i++) begin
      signal_in = DATA_W'(i + 100);
      valid_in  = 1'b1;
      tick();
      vectors++;
      if (valid_out !== (i % 16 == 15)) begin
        miscompares++; $display("FAIL clamp_valid[%0d]: got %b expected %b", i, valid_out, (i % 16 == 15));
      end
      if (i % 16 == 15) begin
        vectors++;
        if (signal_out !== DATA_W'(i + 100)) begin
          miscompares++; $display("FAIL clamp_data[%0d]: got %0d expected %0d", i, signal_out, i + 100);
        end
      end
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    factor_i = 5'd2; out_ready = 1'b0;
    send(16'd10);
    send(16'd20);
    vectors++;
    if (valid_out !== 1'b1 || signal_out !== 16'd20 || overrun_o !== 1'b0) begin
      miscompares++; $display("FAIL ovr_first: got %b/%0d/%b expected 1/20/0", valid_out, signal_out, overrun_o);
    end
    send(16'd30);
    send(16'd40);
    vectors++;
    if (valid_out !== 1'b1 || signal_out !== 16'd20 || overrun_o !== 1'b1) begin
      miscompares++; $display("FAIL ovr_drop: got %b/%0d/%b expected 1/20/1", valid_out, signal_out, overrun_o);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (valid_out !== 1'b0 || signal_out !== 16'd20 || overrun_o !== 1'b1) begin
      miscompares++; $display("FAIL ovr_xfer: got %b/%0d/%b expected 0/20/1", valid_out, signal_out, overrun_o);
    end
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++; $display("FAIL ovr_once: got %b expected 0", valid_out);
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    vectors++;
    if (overrun_o !== 1'b0) begin
      miscompares++; $display("FAIL clear_overrun: got %b expected 0", overrun_o);
    end
    // clear_i beats a same-cycle sample, so 77 never counts
    clear_i = 1'b1; signal_in = 16'd77; valid_in = 1'b1;
    tick();
    clear_i = 1'b0;
    send(16'd88);
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++; $display("FAIL clear_wins: got %b expected 0", valid_out);
    end
    send(16'd99);
    vectors++;
    if (valid_out !== 1'b1 || signal_out !== 16'd99) begin
      miscompares++; $display("FAIL clear_next: got %b/%0d expected 1/99", valid_out, signal_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    factor_i = 5'd2; out_ready = 1'b0;
    send(16'd1);
    send(16'd2);
    send(16'd3);
    out_ready = 1'b1;
    send(16'd4);
    vectors++;
    if (valid_out !== 1'b1 || signal_out !== 16'd4 || overrun_o !== 1'b0) begin
      miscompares++; $display("FAIL no_bubble: got %b/%0d/%b expected 1/4/0", valid_out, signal_out, overrun_o);
    end
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++; $display("FAIL no_bubble_drain: got %b expected 0", valid_out);
    end
  endtask

  task automatic test_gaps_factor_change();
    factor_i = 5'd2; out_ready = 1'b1;
    send(16'd5);
    factor_i = 5'd5;
    tick();
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++; $display("FAIL gap_idle: got %b expected 0", valid_out);
    end
    send(16'd6);
    vectors++;
    if (valid_out !== 1'b1 || signal_out !== 16'd6) begin
      miscompares++; $display("FAIL gap_old_factor: got %b/%0d expected 1/6", valid_out, signal_out);
    end
    for (int k = 0; k < 5; k++) begin
      send(DATA_W'(k + 1));
      vectors++;
      if (valid_out !== (k == 4) || (k == 4 && signal_out !== 16'd5)) begin
        miscompares++; $display("FAIL gap_new_factor[%0d]: got %b/%0d expected %b/5", k, valid_out, signal_out, (k == 4));
      end
      tick();
      tick();
    end
  endtask

`ifdef DECIMATOR_AVG_EN
  task automatic test_avg();
    out_ready = 1'b1; mode_avg_i = 1'b1;
    factor_i = 5'd4;
    send(16'd100); send(16'd200); send(16'd300); send(16'd400);
    vectors++;
    if (valid_out !== 1'b1 || signal_out !== 16'd250) begin
      miscompares++; $display("FAIL avg_250: got %b/%0d expected 1/250", valid_out, signal_out);
    end
    for (int i = 0; i < 4; i++) send(16'h8000);
    vectors++;
    if (signal_out !== 16'h8000) begin
      miscompares++; $display("FAIL avg_min: got %0d expected -32768", $signed(signal_out));
    end
    factor_i = 5'd3;
    for (int i = 0; i < 3; i++) send(16'd30000);
    vectors++;
    if (signal_out !== 16'h7fff) begin
      miscompares++; $display("FAIL avg_sat: got %0d expected 32767", $signed(signal_out));
    end
    factor_i = 5'd2;
    send(16'hfffd); send(16'hfffc);
    vectors++;
    if (signal_out !== 16'hfffc) begin
      miscompares++; $display("FAIL avg_neg_floor: got %0d expected -4", $signed(signal_out));
    end
    mode_avg_i = 1'b0;
    tick();
  endtask
`else
  task automatic test_avg();
    out_ready = 1'b1; mode_avg_i = 1'b1;
    factor_i = 5'd4;
    send(16'd100); send(16'd200); send(16'd300); send(16'd400);
    vectors++;
    if (valid_out !== 1'b1 || signal_out !== 16'd400) begin
      miscompares++; $display("FAIL mode_ignored: got %b/%0d expected 1/400", valid_out, signal_out);
    end
    mode_avg_i = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_frame();
    factor_i = 5'd4; out_ready = 1'b1;
    send(16'd1);
    send(16'd2);
    reset_n = 1'b0;
    #3;
    vectors++;
    if (signal_out !== '0 || valid_out !== 1'b0 || overrun_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid: got %0d/%b/%b expected 0/0/0", signal_out, valid_out, overrun_o);
    end
    reset_n = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      send(DATA_W'(i));
      vectors++;
      if (valid_out !== (i == 6) || (i == 6 && signal_out !== 16'd6)) begin
        miscompares++; $display("FAIL reset_refill[%0d]: got %b/%0d expected %b/6", i, valid_out, signal_out, (i == 6));
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_pick_ramp();
    test_factor_one();
    test_clamp();
    test_overrun();
    test_back_to_back();
    test_gaps_factor_change();
    test_avg();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
